// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the counter-based synchronous FIFO family.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DEPTH      = 512;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Occupancy needs one more bit than the address to represent DEPTH itself.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: drives the dp_ram ports, tracks occupancy and
// produces registered status flags, overflow/underflow pulses and read-valid.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_w_enable,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic [DATA_WIDTH-1:0] ram_w_data,
    output logic                  ram_r_enable,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    input  logic [DATA_WIDTH-1:0] ram_r_data
);

    localparam int CNT_W = count_width(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    if (DEPTH != (1 << ADDR_WIDTH) || AE_THRESH >= AF_THRESH) begin : g_param_check
        $error("sync_fifo_ctrl: DEPTH must be 2**ADDR_WIDTH and AE_THRESH < AF_THRESH");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic full_q, full_d, empty_q, empty_d;
    logic almost_full_q, almost_full_d, almost_empty_q, almost_empty_d;
    logic overflow_q, overflow_d, underflow_q, underflow_d;
    logic rd_valid_q, rd_valid_d;
    logic wr_acc, rd_acc;

    // Acceptance uses the registered flags, so a read of an empty FIFO can never
    // race a same-cycle write to the same RAM address.
    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Flags come from the next count so they line up with count itself.
        full_d         = (count_d == DEPTH_C);
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= AF_C);
        almost_empty_d = (count_d <= AE_C);
        overflow_d     = wr_en & full_q;
        underflow_d    = rd_en & empty_q;
        rd_valid_d     = rd_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            rd_valid_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            rd_valid_q     <= rd_valid_d;
        end
    end

    assign ram_w_enable = wr_acc;
    assign ram_w_addr   = wr_ptr_q;
    assign ram_w_data   = wr_data;
    assign ram_r_enable = rd_acc;
    assign ram_r_addr   = rd_ptr_q;
    assign rd_data      = ram_r_data;

    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: queue-based reference model checked every cycle,
// a behavioural dual-port RAM, and directed scenarios with literal expectations.
module tb_sync_fifo_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int DEP = 8;
    localparam int AF  = 6;
    localparam int AE  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;
    logic          ram_w_enable, ram_r_enable;
    logic [AW-1:0] ram_w_addr, ram_r_addr;
    logic [DW-1:0] ram_w_data, ram_r_data;

    int vectors = 0;
    int miscompares = 0;

    sync_fifo_ctrl #(
        .DATA_WIDTH(DW), .DEPTH(DEP), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow),
        .ram_w_enable(ram_w_enable), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_r_enable(ram_r_enable), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
    );

    always #5 clk = ~clk;

    // Registered-read dual-port RAM standing in for dp_ram.
    logic [DW-1:0] mem [DEP];
    always @(posedge clk) begin
        if (ram_w_enable) mem[ram_w_addr] <= ram_w_data;
        if (ram_r_enable) ram_r_data <= mem[ram_r_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the FIFO contents as a queue plus write/read counts.
    logic [DW-1:0] mq[$];
    int            m_wptr = 0, m_rptr = 0;
    bit            m_valid = 0, m_ovf = 0, m_udf = 0;
    logic [DW-1:0] m_data = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_wptr = 0; m_rptr = 0;
            m_valid = 0; m_ovf = 0; m_udf = 0;
        end else begin
            automatic bit was_full  = (mq.size() == DEP);
            automatic bit was_empty = (mq.size() == 0);
            m_ovf   = wr_en && was_full;
            m_udf   = rd_en && was_empty;
            m_valid = rd_en && !was_empty;
            if (rd_en && !was_empty) begin
                m_data = mq.pop_front();
                m_rptr = (m_rptr + 1) % DEP;
            end
            if (wr_en && !was_full) begin
                mq.push_back(wr_data);
                m_wptr = (m_wptr + 1) % DEP;
            end
        end
    end

    // Every-cycle comparison, one time unit after the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                check("count", 32'(count), 32'(mq.size()));
                check("empty", 32'(empty), 32'(mq.size() == 0));
                check("full", 32'(full), 32'(mq.size() == DEP));
                check("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
                check("almost_empty", 32'(almost_empty), 32'(mq.size() <= AE));
                check("overflow", 32'(overflow), 32'(m_ovf));
                check("underflow", 32'(underflow), 32'(m_udf));
                check("rd_valid", 32'(rd_valid), 32'(m_valid));
                if (m_valid) check("rd_data", 32'(rd_data), 32'(m_data));
                check("ram_w_enable", 32'(ram_w_enable), 32'(wr_en && mq.size() < DEP));
                check("ram_w_addr", 32'(ram_w_addr), 32'(m_wptr));
                check("ram_w_data", 32'(ram_w_data), 32'(wr_data));
                check("ram_r_enable", 32'(ram_r_enable), 32'(rd_en && mq.size() > 0));
                check("ram_r_addr", 32'(ram_r_addr), 32'(m_rptr));
            end
        end
    end

    // Apply one cycle of inputs; on return the previous cycle's effects are visible.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        @(negedge clk);
        #2;
        wr_en = w;
        wr_data = d;
        rd_en = r;
    endtask

    initial begin
        logic [AW-1:0] saved_raddr;

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_almost_empty", 32'(almost_empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_ram_w_enable", 32'(ram_w_enable), 0);

        // Fill 0x10..0x17, then one write too many.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0);
            check("fill_count", 32'(count), 32'(i));
            check("fill_almost_full", 32'(almost_full), 32'(i >= 6));
        end
        step(1'b0, 8'h00, 1'b0);
        check("ovf_count", 32'(count), 8);
        check("ovf_full", 32'(full), 1);
        check("ovf_pulse", 32'(overflow), 1);
        step(1'b0, 8'h00, 1'b0);
        check("ovf_pulse_end", 32'(overflow), 0);

        // Drain in order.
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 8'h00, i < 8);
            if (i > 0) begin
                check("drain_valid", 32'(rd_valid), 1);
                check("drain_data", 32'(rd_data), 32'(8'h10 + i - 1));
            end
        end
        check("drain_empty", 32'(empty), 1);

        // Wrap-around: move both pointers to 5, then write six words across 7->0.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'(8'hA0 + i), 1'b0);
            #1 check("wrap_w_addr", 32'(ram_w_addr), 32'((5 + i) % 8));
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 8'h00, i < 6);
            if (i > 0) check("wrap_data", 32'(rd_data), 32'(8'hA0 + i - 1));
        end

        // Simultaneous read and write in the middle, at full and at empty.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("rw_mid_count", 32'(count), 3);
        check("rw_mid_ovf", 32'(overflow), 0);
        check("rw_mid_udf", 32'(underflow), 0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("rw_full_count", 32'(count), 7);
        check("rw_full_ovf", 32'(overflow), 1);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h77, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("rw_empty_count", 32'(count), 1);
        check("rw_empty_udf", 32'(underflow), 1);
        check("rw_empty_rd_valid", 32'(rd_valid), 0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("rw_empty_data", 32'(rd_data), 32'h77);

        // Underflow on an empty FIFO.
        saved_raddr = ram_r_addr;
        step(1'b0, 8'h00, 1'b1);
        #1 check("udf_r_enable", 32'(ram_r_enable), 0);
        step(1'b0, 8'h00, 1'b0);
        check("udf_pulse", 32'(underflow), 1);
        check("udf_r_addr", 32'(ram_r_addr), 32'(saved_raddr));
        step(1'b0, 8'h00, 1'b0);
        check("udf_pulse_end", 32'(underflow), 0);

        // Reset asserted between edges while a read is in flight.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #2;
        check("pre_rst_valid", 32'(rd_valid), 1);
        check("pre_rst_count", 32'(count), 5);
        rst_n = 1'b0;
        rd_en = 1'b0;
        #1;
        check("midrst_rd_valid", 32'(rd_valid), 0);
        check("midrst_count", 32'(count), 0);
        check("midrst_empty", 32'(empty), 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("post_rst_valid", 32'(rd_valid), 1);
        check("post_rst_data", 32'(rd_data), 32'h55);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
